// File: rtl/alu_seq_unit.sv
// alu_seq_unit: operand muxes, single-cycle ALU, iterative shifter and an
// optional shift-add multiplier feeding a registered result with status flags.
// Optional feature macro: ALU_SEQ_MUL_EN builds the WIDTH-cycle multiplier;
// without it ALUOP 111 completes in one cycle with a zero result.
module alu_seq_unit #(
   parameter int WIDTH   = 16,
   parameter int CONST_B = 2,
   parameter int SHW     = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] PC,
   input  logic [WIDTH-1:0] ACC,
   input  logic [WIDTH-1:0] SP,
   input  logic [WIDTH-1:0] MDR,
   input  logic [WIDTH-1:0] SE,
   input  logic [WIDTH-1:0] ZE,
   input  logic [WIDTH-1:0] SL1,
   input  logic [1:0]       SrcA,
   input  logic [2:0]       SrcB,
   input  logic [2:0]       ALUOP,
   output logic [WIDTH-1:0] Out,
   output logic [WIDTH-1:0] aluOut,
   output logic             Zero,
   output logic             Carry,
   output logic             Neg,
   output logic             Ovf,
   output logic             Busy,
   output logic             Done
);

   localparam int CNTW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ITER = 2'b01,
      FIN  = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   count_q, count_d;
   logic [2:0]        op_q, op_d;
   logic [WIDTH-1:0]  work_q, work_d;
   logic [WIDTH-1:0]  alu_out_q, alu_out_d;
   logic              zero_q, zero_d;
   logic              carry_q, carry_d;
   logic              neg_q, neg_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;

   logic [WIDTH-1:0]  mux_a;
   logic [WIDTH-1:0]  mux_b;
   logic [SHW-1:0]    shamt;
   logic [WIDTH:0]    add_full;
   logic [WIDTH-1:0]  sub_res;
   logic [WIDTH-1:0]  alu_res;
   logic              alu_carry;
   logic              alu_ovf;
   logic [WIDTH-1:0]  step_val;
   logic              step_out;

   logic              wr_en;
   logic [WIDTH-1:0]  wr_val;
   logic              wr_carry;
   logic              wr_ovf;

`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH:0]    mul_sum;
   logic [WIDTH-1:0]  mul_hi;
   logic [WIDTH-1:0]  mul_lo;
`endif

   // Select the A and B operands from the datapath candidates.
   always_comb begin
      mux_a = '0;
      mux_b = '0;
      case (SrcA)
         2'b00:   mux_a = PC;
         2'b01:   mux_a = ACC;
         2'b10:   mux_a = SP;
         default: mux_a = '0;
      endcase
      case (SrcB)
         3'b000:  mux_b = WIDTH'(CONST_B);
         3'b001:  mux_b = SE;
         3'b010:  mux_b = MDR;
         3'b011:  mux_b = ZE;
         3'b100:  mux_b = SL1;
         default: mux_b = '0;
      endcase
   end

   assign shamt = mux_b[SHW-1:0];

   // Single-cycle ALU on the live muxed operands, with carry and overflow.
   always_comb begin
      add_full  = {1'b0, mux_a} + {1'b0, mux_b};
      sub_res   = mux_a - mux_b;
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (ALUOP)
         OP_ADD: begin
            alu_res   = add_full[WIDTH-1:0];
            alu_carry = add_full[WIDTH];
            alu_ovf   = (mux_a[WIDTH-1] == mux_b[WIDTH-1]) &&
                        (add_full[WIDTH-1] != mux_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res   = sub_res;
            alu_carry = (mux_a >= mux_b);
            alu_ovf   = (mux_a[WIDTH-1] != mux_b[WIDTH-1]) &&
                        (sub_res[WIDTH-1] != mux_a[WIDTH-1]);
         end
         OP_AND:  alu_res = mux_a & mux_b;
         OP_OR:   alu_res = mux_a | mux_b;
         OP_XOR:  alu_res = mux_a ^ mux_b;
         OP_SLL:  alu_res = mux_a;
         OP_SRL:  alu_res = mux_a;
         OP_MUL:  alu_res = '0;
         default: alu_res = '0;
      endcase
   end

   // Out shows the arithmetic/logic result, or the B operand for other ops.
   assign Out = (ALUOP <= OP_XOR) ? alu_res : mux_b;

   // One-bit shift step of the working register and the bit it drops.
   always_comb begin
      step_val = work_q;
      step_out = 1'b0;
      case (op_q)
         OP_SLL: begin
            step_val = {work_q[WIDTH-2:0], 1'b0};
            step_out = work_q[WIDTH-1];
         end
         OP_SRL: begin
            step_val = {1'b0, work_q[WIDTH-1:1]};
            step_out = work_q[0];
         end
         default: begin
            step_val = work_q;
            step_out = 1'b0;
         end
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   // One add-and-shift multiply step: work holds the high half, b the low half.
   always_comb begin
      mul_sum = {1'b0, work_q} + ({1'b0, a_q} & {(WIDTH + 1){b_q[0]}});
      mul_hi  = mul_sum[WIDTH:1];
      mul_lo  = {mul_sum[0], b_q[WIDTH-1:1]};
   end
`endif

   // Sequencer: accept new ops, run iterations, and commit result and flags.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_d      = op_q;
      work_d    = work_q;
      alu_out_d = alu_out_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      neg_d     = neg_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      wr_en     = 1'b0;
      wr_val    = '0;
      wr_carry  = 1'b0;
      wr_ovf    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      a_d       = a_q;
      b_d       = b_q;
`endif
      case (state_q)
         ITER: begin
            count_d = count_q - CNTW'(1);
            state_d = (count_q == CNTW'(1)) ? FIN : ITER;
`ifdef ALU_SEQ_MUL_EN
            if (op_q == OP_MUL) begin
               work_d = mul_hi;
               b_d    = mul_lo;
               if (count_q == CNTW'(1)) begin
                  wr_en    = 1'b1;
                  wr_val   = mul_lo;
                  wr_carry = |mul_hi;
               end
            end else begin
               work_d = step_val;
               if (count_q == CNTW'(1)) begin
                  wr_en    = 1'b1;
                  wr_val   = step_val;
                  wr_carry = step_out;
               end
            end
`else
            work_d = step_val;
            if (count_q == CNTW'(1)) begin
               wr_en    = 1'b1;
               wr_val   = step_val;
               wr_carry = step_out;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            if (Start) begin
               op_d = ALUOP;
               if (((ALUOP == OP_SLL) || (ALUOP == OP_SRL)) && (shamt != '0)) begin
                  state_d = ITER;
                  count_d = CNTW'(shamt);
                  work_d  = mux_a;
`ifdef ALU_SEQ_MUL_EN
               end else if (ALUOP == OP_MUL) begin
                  state_d = ITER;
                  count_d = CNTW'(WIDTH);
                  work_d  = '0;
                  a_d     = mux_a;
                  b_d     = mux_b;
`endif
               end else begin
                  wr_en    = 1'b1;
                  wr_val   = alu_res;
                  wr_carry = alu_carry;
                  wr_ovf   = alu_ovf;
               end
            end
         end
      endcase
      if (wr_en) begin
         alu_out_d = wr_val;
         zero_d    = (wr_val == '0);
         neg_d     = wr_val[WIDTH-1];
         carry_d   = wr_carry;
         ovf_d     = wr_ovf;
         done_d    = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         op_q      <= '0;
         work_q    <= '0;
         alu_out_q <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         a_q       <= '0;
         b_q       <= '0;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         op_q      <= op_d;
         work_q    <= work_d;
         alu_out_q <= alu_out_d;
         zero_q    <= zero_d;
         carry_q   <= carry_d;
         neg_q     <= neg_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
`ifdef ALU_SEQ_MUL_EN
         a_q       <= a_d;
         b_q       <= b_d;
`endif
      end
   end

   assign aluOut = alu_out_q;
   assign Zero   = zero_q;
   assign Carry  = carry_q;
   assign Neg    = neg_q;
   assign Ovf    = ovf_q;
   assign Busy   = (state_q == ITER);
   assign Done   = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard testbench for alu_seq_unit: each issued op pushes its expected
// result, flags and Done cycle; a negedge monitor pops and compares on Done.
module tb_alu_seq_unit;

   typedef struct {
      logic [15:0] val;
      logic [3:0]  flags;
      int          cyc;
   } exp_t;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        Start;
   logic [15:0] pc, acc, sp, mdr, se, ze, sl1;
   logic [1:0]  srcA;
   logic [2:0]  srcB;
   logic [2:0]  aluOp;
   logic [15:0] outC;
   logic [15:0] aluOut;
   logic        zero, carry, neg, ovf, busy, done;

   exp_t        sbq[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] prevOut = '0;
   logic        prevReset = 1'b1;

   alu_seq_unit #(.WIDTH(16), .CONST_B(2)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start),
      .PC(pc), .ACC(acc), .SP(sp),
      .MDR(mdr), .SE(se), .ZE(ze), .SL1(sl1),
      .SrcA(srcA), .SrcB(srcB), .ALUOP(aluOp),
      .Out(outC), .aluOut(aluOut),
      .Zero(zero), .Carry(carry), .Neg(neg), .Ovf(ovf),
      .Busy(busy), .Done(done)
   );

   // Free-running clock and cycle counter.
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: pop and compare on every Done; aluOut may only move with Done.
   always @(negedge CLK) begin
      exp_t e;
      if (!Reset && done) begin
         if (sbq.size() == 0) begin
            checkOutput("spurious_done", 1, 0);
         end else begin
            e = sbq.pop_front();
            checkOutput("aluOut", int'(aluOut), int'(e.val));
            checkOutput("flags_ZCNO", int'({zero, carry, neg, ovf}), int'(e.flags));
            checkOutput("done_cycle", cyc, e.cyc);
         end
      end
      if (!prevReset && !Reset && (aluOut !== prevOut))
         checkOutput("aluOut_moved_with_done", int'(done), 1);
      prevOut   = aluOut;
      prevReset = Reset;
   end

   // Issue one op in the current cycle, push its expectation, and step through
   // its latency checking Busy; returns in the Done cycle, #1 after the edge.
   task automatic applyStimulus(input logic [1:0] sa, input logic [2:0] sb,
                                input logic [2:0] op, input int k,
                                input logic [15:0] ev, input logic [3:0] ef,
                                input bit keep);
      exp_t e;
      srcA  = sa;
      srcB  = sb;
      aluOp = op;
      Start = 1'b1;
      e.val   = ev;
      e.flags = ef;
      e.cyc   = cyc + 1 + k;
      sbq.push_back(e);
      for (int i = 1; i <= k + 1; i++) begin
         @(posedge CLK);
         #1;
         if (!keep) Start = 1'b0;
         checkOutput("busy", int'(busy), (i <= k) ? 1 : 0);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Reset = 1'b1; Start = 1'b0;
      pc = '0; acc = '0; sp = '0; mdr = '0; se = '0; ze = '0; sl1 = '0;
      srcA = 2'b00; srcB = 3'b000; aluOp = 3'b000;
      repeat (3) @(posedge CLK);
      #1;
      Reset = 1'b0;
      checkOutput("reset_aluOut", int'(aluOut), 0);
      checkOutput("reset_flags", int'({zero, carry, neg, ovf}), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);

      // Combinational Out: logic result for ADD..XOR, B operand otherwise.
      acc = 16'h00F0; mdr = 16'h0F0F; srcA = 2'b01; srcB = 3'b010;
      aluOp = 3'b011; #1;
      checkOutput("Out_or", int'(outC), 16'h0FFF);
      aluOp = 3'b101; #1;
      checkOutput("Out_sll_is_b", int'(outC), 16'h0F0F);
      @(posedge CLK); #1;

      // PC + CONST_B
      pc = 16'h0010;
      applyStimulus(2'b00, 3'b000, 3'b000, 0, 16'h0012, 4'b0000, 0);
      // Signed overflow on ADD
      acc = 16'h7FFF; mdr = 16'h0001;
      applyStimulus(2'b01, 3'b010, 3'b000, 0, 16'h8000, 4'b0011, 0);
      // SUB equal: zero, no borrow
      acc = 16'h1234; mdr = 16'h1234;
      applyStimulus(2'b01, 3'b010, 3'b001, 0, 16'h0000, 4'b1100, 0);
      // SUB with borrow
      acc = 16'h0001; mdr = 16'h0002;
      applyStimulus(2'b01, 3'b010, 3'b001, 0, 16'hFFFF, 4'b0010, 0);
      // ADD carry-out, no overflow
      acc = 16'hFFFF; mdr = 16'h0001;
      applyStimulus(2'b01, 3'b010, 3'b000, 0, 16'h0000, 4'b1100, 0);
      // ADD two negatives: carry and overflow
      acc = 16'h8000; mdr = 16'h8000;
      applyStimulus(2'b01, 3'b010, 3'b000, 0, 16'h0000, 4'b1101, 0);
      // Logic ops
      acc = 16'hF0F0; mdr = 16'h0FF0;
      applyStimulus(2'b01, 3'b010, 3'b010, 0, 16'h00F0, 4'b0000, 0);
      applyStimulus(2'b01, 3'b010, 3'b011, 0, 16'hFFF0, 4'b0010, 0);
      applyStimulus(2'b01, 3'b010, 3'b100, 0, 16'hFF00, 4'b0010, 0);
      // SrcA zero, SrcB unused code
      applyStimulus(2'b11, 3'b101, 3'b000, 0, 16'h0000, 4'b1000, 0);
      // SLL by 3 of 0x8001
      acc = 16'h8001; ze = 16'h0003;
      applyStimulus(2'b01, 3'b011, 3'b101, 3, 16'h0008, 4'b0000, 0);
      // SRL by 1 of 0x8001
      ze = 16'h0001;
      applyStimulus(2'b01, 3'b011, 3'b110, 1, 16'h4000, 4'b0100, 0);
      // Shift amount field is zero: single-cycle, Carry=0
      ze = 16'h0010;
      applyStimulus(2'b01, 3'b011, 3'b101, 0, 16'h8001, 4'b0010, 0);
      // SLL by 15 of 0xFFFF: last bit out is a 1
      acc = 16'hFFFF; ze = 16'h000F;
      applyStimulus(2'b01, 3'b011, 3'b101, 15, 16'h8000, 4'b0110, 0);
      // Multiply
      acc = 16'h0100; mdr = 16'h0300;
`ifdef ALU_SEQ_MUL_EN
      applyStimulus(2'b01, 3'b010, 3'b111, 16, 16'h0000, 4'b1100, 0);
      acc = 16'h0003; mdr = 16'h0005;
      applyStimulus(2'b01, 3'b010, 3'b111, 16, 16'h000F, 4'b0000, 0);
`else
      applyStimulus(2'b01, 3'b010, 3'b111, 0, 16'h0000, 4'b1000, 0);
      acc = 16'h0003; mdr = 16'h0005;
      applyStimulus(2'b01, 3'b010, 3'b111, 0, 16'h0000, 4'b1000, 0);
`endif

      // Reset in the middle of SLL-by-5: no Done, state cleared.
      acc = 16'h0001; ze = 16'h0005; srcA = 2'b01; srcB = 3'b011; aluOp = 3'b101;
      Start = 1'b1;
      @(posedge CLK); #1;
      Start = 1'b0;
      checkOutput("busy_before_reset", int'(busy), 1);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      Reset = 1'b1;
      @(posedge CLK); #1;
      Reset = 1'b0;
      checkOutput("midreset_aluOut", int'(aluOut), 0);
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_done", int'(done), 0);
      checkOutput("midreset_flags", int'({zero, carry, neg, ovf}), 0);
      repeat (6) @(posedge CLK);
      #1;
      // Fresh ADD after reset
      acc = 16'h0005; mdr = 16'h0007;
      applyStimulus(2'b01, 3'b010, 3'b000, 0, 16'h000C, 4'b0000, 0);

      // Start held through SLL-by-2; second op accepted in the Done cycle.
      acc = 16'h0003; ze = 16'h0002;
      applyStimulus(2'b01, 3'b011, 3'b101, 2, 16'h000C, 4'b0000, 1);
      mdr = 16'h0005;
      applyStimulus(2'b01, 3'b010, 3'b001, 0, 16'hFFFE, 4'b0010, 0);

      repeat (4) @(posedge CLK);
      #1;
      checkOutput("scoreboard_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
